// File: rtl/alu_pkg.sv
// Shared ALU encodings: control codes consumed by the ALU and ALUOp classes
// produced by the main decoder.
package alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_BAD = 4'b1111;

   typedef enum logic [1:0] {
      ALUOP_LS = 2'b00,
      ALUOP_BR = 2'b01,
      ALUOP_R  = 2'b10,
      ALUOP_I  = 2'b11
   } aluop_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct decoder producing the 4-bit ALU control code and
// an illegal-combination flag.
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [1:0] ALUOp,
   input  logic       funct7_b30,
   input  logic [2:0] funct3,
   output logic [3:0] ALUcontrol,
   output logic       illegal_op
);

   always_comb begin
      ALUcontrol = ALU_BAD;
      illegal_op = 1'b0;
      case (aluop_e'(ALUOp))
         ALUOP_LS: ALUcontrol = ALU_ADD;
         ALUOP_BR: ALUcontrol = ALU_SUB;
         ALUOP_R: begin
            case ({funct7_b30, funct3})
               4'b0000: ALUcontrol = ALU_ADD;
               4'b1000: ALUcontrol = ALU_SUB;
               4'b0111: ALUcontrol = ALU_AND;
               4'b0110: ALUcontrol = ALU_OR;
               default: illegal_op = 1'b1;
            endcase
         end
         ALUOP_I: begin
            // Bit 30 is part of the immediate for I-type, so it is ignored here.
            case (funct3)
               3'b000:  ALUcontrol = ALU_ADD;
               3'b111:  ALUcontrol = ALU_AND;
               3'b110:  ALUcontrol = ALU_OR;
               default: illegal_op = 1'b1;
            endcase
         end
         default: illegal_op = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX boundary register feeding the ALU: resolves operand forwarding,
// selects the immediate, decodes ALU control, with valid/ready, stall and flush.
module alu_operand_stage
   import alu_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [RA_W-1:0] rs1_addr,
   input  logic [RA_W-1:0] rs2_addr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm,
   input  logic            ALUSrc,
   input  logic [1:0]      ALUOp,
   input  logic            funct7_b30,
   input  logic [2:0]      funct3,
   input  logic            exmem_wen,
   input  logic [RA_W-1:0] exmem_rd,
   input  logic [XLEN-1:0] exmem_data,
   input  logic            memwb_wen,
   input  logic [RA_W-1:0] memwb_rd,
   input  logic [XLEN-1:0] memwb_data,
   input  logic            flush,
   input  logic            out_ready,
   output logic            out_valid,
   output logic [XLEN-1:0] I1,
   output logic [XLEN-1:0] I2,
   output logic [3:0]      ALUcontrol,
   output logic [XLEN-1:0] store_data,
   output logic            illegal_op
);

   logic            r_valid_p0;
   logic [XLEN-1:0] r_i1_p0;
   logic [XLEN-1:0] r_i2_p0;
   logic [3:0]      r_ctrl_p0;
   logic [XLEN-1:0] r_store_p0;
   logic            r_illegal_p0;

   logic [XLEN-1:0] w_fwd_rs1;
   logic [XLEN-1:0] w_fwd_rs2;
   logic [3:0]      w_ctrl;
   logic            w_illegal;
   logic            w_load;

   // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is hardwired.
   function automatic logic [XLEN-1:0] fwd_sel(
      input logic [RA_W-1:0] rs,
      input logic [XLEN-1:0] rf_data,
      input logic            ex_wen,
      input logic [RA_W-1:0] ex_rd,
      input logic [XLEN-1:0] ex_data,
      input logic            wb_wen,
      input logic [RA_W-1:0] wb_rd,
      input logic [XLEN-1:0] wb_data
   );
      if (rs == '0)
         return rf_data;
      else if (ex_wen && (ex_rd == rs))
         return ex_data;
      else if (wb_wen && (wb_rd == rs))
         return wb_data;
      else
         return rf_data;
   endfunction

   assign w_fwd_rs1 = fwd_sel(rs1_addr, rs1_data, exmem_wen, exmem_rd, exmem_data,
                              memwb_wen, memwb_rd, memwb_data);
   assign w_fwd_rs2 = fwd_sel(rs2_addr, rs2_data, exmem_wen, exmem_rd, exmem_data,
                              memwb_wen, memwb_rd, memwb_data);

   alu_ctrl_decode u_dec (
      .ALUOp      (ALUOp),
      .funct7_b30 (funct7_b30),
      .funct3     (funct3),
      .ALUcontrol (w_ctrl),
      .illegal_op (w_illegal)
   );

   assign in_ready = !r_valid_p0 || out_ready;
   assign w_load   = in_valid && in_ready && !flush;

   // ---- ID/EX register boundary ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid_p0   <= 1'b0;
         r_i1_p0      <= '0;
         r_i2_p0      <= '0;
         r_ctrl_p0    <= ALU_BAD;
         r_store_p0   <= '0;
         r_illegal_p0 <= 1'b0;
      end else if (flush) begin
         r_valid_p0 <= 1'b0;
      end else if (w_load) begin
         r_valid_p0   <= 1'b1;
         r_i1_p0      <= w_fwd_rs1;
         r_i2_p0      <= ALUSrc ? imm : w_fwd_rs2;
         r_ctrl_p0    <= w_ctrl;
         r_store_p0   <= w_fwd_rs2;
         r_illegal_p0 <= w_illegal;
      end else if (out_ready) begin
         r_valid_p0 <= 1'b0;
      end
   end

   assign out_valid  = r_valid_p0;
   assign I1         = r_i1_p0;
   assign I2         = r_i2_p0;
   assign ALUcontrol = r_ctrl_p0;
   assign store_data = r_store_p0;
   assign illegal_op = r_illegal_p0;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered ID/EX boundary stage sitting directly upstream of the 64-bit ALU.
- Each cycle it accepts one decoded instruction and resolves forwarding for both source operands.
- It selects the immediate or register value for the second operand and decodes ALUOp/funct fields into the 4-bit ALU control code.
- Registered I1/I2/ALUcontrol drive the ALU next cycle; the stage has a valid/ready handshake, a stall path and a flush path.

Parameters:
- XLEN, 64, datapath width of operands and immediate.
- RA_W, 5, register-address width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept this cycle.
- rs1_addr, rs2_addr  input  RA_W  source register numbers.
- rs1_data, rs2_data  input  XLEN  register-file read data.
- imm  input  XLEN  sign-extended immediate.
- ALUSrc  input  1  1 selects imm for I2.
- ALUOp  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type arithmetic.
- funct7_b30  input  1  instruction bit 30.
- funct3  input  3  instruction funct3.
- exmem_wen  input  1  EX/MEM writes back.
- exmem_rd  input  RA_W  EX/MEM destination register.
- exmem_data  input  XLEN  EX/MEM result.
- memwb_wen  input  1  MEM/WB writes back.
- memwb_rd  input  RA_W  MEM/WB destination register.
- memwb_data  input  XLEN  MEM/WB result.
- flush  input  1  squash held and incoming instruction.
- out_ready  input  1  downstream (ALU/EX) can take the output.
- out_valid  output  1  I1/I2/ALUcontrol valid.
- I1  output  XLEN  ALU operand 1.
- I2  output  XLEN  ALU operand 2.
- ALUcontrol  output  4  ALU operation code.
- store_data  output  XLEN  forwarded rs2 value, for stores.
- illegal_op  output  1  unsupported ALUOp/funct combination.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, I1=0, I2=0, ALUcontrol=4'b1111, store_data=0, illegal_op=0. Reset asserted mid-transfer drops the held instruction.
- in_ready = !out_valid || out_ready. This is purely combinational; it is never a function of in_valid.
- Load condition: in_valid && in_ready && !flush. Register all outputs and set out_valid=1. Latency is one cycle from acceptance to out_valid.
- Drain: out_valid && out_ready with no new load clears out_valid to 0. Load and drain in the same cycle keep out_valid=1 with the new data.
- Stall: out_valid && !out_ready holds every output bit-stable, and in_ready=0.
- Flush: has priority over everything. Next cycle out_valid=0 and the incoming instruction is discarded; data registers may keep stale values.
- Forwarding, evaluated per source (rs1, rs2) at load time:
  - Priority 1: exmem_wen && exmem_rd==rsX && rsX!=0 selects exmem_data.
  - Priority 2: memwb_wen && memwb_rd==rsX && rsX!=0 selects memwb_data.
  - Otherwise: register-file data.
  - Register x0 is never forwarded; its value is rsX_data.
- I1 = fwd_rs1. I2 = ALUSrc ? imm : fwd_rs2. store_data = fwd_rs2 regardless of ALUSrc.
- ALU control decode:
  - ALUOp 00 gives 0010 (add).
  - ALUOp 01 gives 0110 (sub).
  - ALUOp 10 (R-type), keyed on {funct7_b30, funct3}: {0,000}=0010, {1,000}=0110, {0,111}=0000, {0,110}=0001.
  - ALUOp 11 (I-type), keyed on funct3 with bit 30 ignored: 000=0010, 111=0000, 110=0001.
  - Any other combination gives ALUcontrol=4'b1111 and illegal_op=1. Otherwise illegal_op=0.
  - illegal_op is registered alongside the data. out_valid still asserts, and the consumer traps.
- No arithmetic in this stage; all values pass through unmodified at full XLEN width.

Decomposition:
- Shared package alu_pkg holds:
  - ALU control constants ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_BAD=4'b1111.
  - ALUOp encodings ALUOP_LS, ALUOP_BR, ALUOP_R, ALUOP_I.
  - The ALU consumes the same constants.
- One combinational sub-module, alu_ctrl_decode (ALUOp, funct7_b30, funct3 -> ALUcontrol, illegal_op), reusable by other decoders.
- The forwarding muxes and pipeline register stay in this module.

Test Plan:
- Reset and basic ADD:
  - Stimulus: assert rst_n=0 mid-stream, then release; load R-type add with rs1=3, rs2=4, rs1_data=10, rs2_data=20, no forwarding.
  - Required: outputs at reset values during reset. Next cycle out_valid=1, I1=10, I2=20, ALUcontrol=0010.
- Immediate and decode:
  - Stimulus: ALUSrc=1, imm=-8 (64'hFFFF_FFFF_FFFF_FFF8), ALUOp=11, funct3=111.
  - Required: I2=64'hFFFF_FFFF_FFFF_FFF8, ALUcontrol=0000, store_data=forwarded rs2 value.
- Forwarding priority:
  - Stimulus: rs1=5, exmem_rd=5 with exmem_data=0xAA, memwb_rd=5 with memwb_data=0xBB, both wen=1.
  - Required: I1=0xAA.
  - Repeat with exmem_wen=0: I1=0xBB.
  - Repeat with rs1=0: I1=rs1_data.
- Stall:
  - Stimulus: out_ready=0 for 3 cycles while in_valid=1 with new data.
  - Required: in_ready=0 and outputs unchanged for those 3 cycles. On out_ready=1 the new instruction loads the following cycle.
- Flush:
  - Stimulus: flush=1 coincident with in_valid=1 while holding a valid instruction.
  - Required: out_valid=0 next cycle; the incoming instruction never appears.
- Illegal:
  - Stimulus: ALUOp=10, funct7_b30=1, funct3=111.
  - Required: ALUcontrol=1111, illegal_op=1, out_valid=1.
